// File: rtl/invaders_io.sv
// invaders_io: i8080 port-mapped I/O target for the invaders cabinet.
// Provides the switch input ports, the 16-bit barrel-shift helper, two sound
// latches with rising-edge trigger pulses, a watchdog, and READY wait states
// on reads. The data bus is shared with the ROM, so it is released whenever
// this block is not actively returning a read value.
module invaders_io #(
    parameter int WAIT_STATES = 1,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] port_addr,
    inout  wire  [7:0] data,
    input  logic       io_rd,
    input  logic       io_wr,
    output logic       ready,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic [7:0] snd1,
    output logic [7:0] snd2,
    output logic [7:0] snd1_trig,
    output logic [7:0] snd2_trig,
    output logic       wdog_expire
);

    localparam int              WDW     = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDW-1:0]  WD_LAST = WDW'(WDOG_CYCLES - 1);
    localparam logic [3:0]      WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [7:0]     r_rd_q;
    logic [15:0]    r_shift_data;
    logic [2:0]     r_shift_off;
    logic [7:0]     r_snd1;
    logic [7:0]     r_snd2;
    logic [7:0]     r_snd1_trig;
    logic [7:0]     r_snd2_trig;
    logic [WDW-1:0] r_wd;

    logic           w_wr2;
    logic           w_wr3;
    logic           w_wr4;
    logic           w_wr5;
    logic           w_wr6;
    logic           w_claim;
    logic [7:0]     w_rd_val;
    logic [3:0]     w_msb;
    logic           w_cap;
    logic           w_oe;
    logic           w_wd_hit;

    // Write strobes; a write is honoured even when io_rd is also high.
    assign w_wr2 = io_wr && (port_addr == 8'd2);
    assign w_wr3 = io_wr && (port_addr == 8'd3);
    assign w_wr4 = io_wr && (port_addr == 8'd4);
    assign w_wr5 = io_wr && (port_addr == 8'd5);
    assign w_wr6 = io_wr && (port_addr == 8'd6);

    // Shifter window: bits 15..8 of (shift_data << shift_off) is an 8-bit
    // slice whose top bit walks down from 15 as the offset grows.
    assign w_msb = 4'd15 - {1'b0, r_shift_off};

    // Read decode: ports 0..3 are claimed, everything else is left alone.
    always_comb begin
        w_claim  = 1'b1;
        w_rd_val = 8'h00;
        case (port_addr)
            8'd0:    w_rd_val = in0;
            8'd1:    w_rd_val = in1;
            8'd2:    w_rd_val = in2;
            8'd3:    w_rd_val = r_shift_data[w_msb -: 8];
            default: w_claim  = 1'b0;
        endcase
    end

    // A read is captured only from IDLE and only when no write competes.
    assign w_cap = (r_state == S_IDLE) && io_rd && !io_wr && w_claim;

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Read FSM next state and bus handshake outputs.
    always_comb begin
        w_next = r_state;
        ready  = 1'b1;
        w_oe   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cap) w_next = (WAIT_STATES == 0) ? S_DRIVE : S_WAIT;
            end
            S_WAIT: begin
                ready = 1'b0;
                if (r_cnt <= 4'd1) w_next = S_DRIVE;
            end
            S_DRIVE: begin
                w_oe = io_rd;
                if (!io_rd) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Captured read value and wait-state counter; value is frozen at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 4'd0;
            r_rd_q <= 8'h00;
        end else if (w_cap) begin
            r_cnt  <= WS_LOAD;
            r_rd_q <= w_rd_val;
        end else if (r_state == S_WAIT) begin
            r_cnt  <= r_cnt - 4'd1;
        end
    end

    assign data = w_oe ? r_rd_q : 8'hzz;

    // Shifter, sound latches and their one-cycle rising-bit pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_data <= 16'h0000;
            r_shift_off  <= 3'd0;
            r_snd1       <= 8'h00;
            r_snd2       <= 8'h00;
            r_snd1_trig  <= 8'h00;
            r_snd2_trig  <= 8'h00;
        end else begin
            r_snd1_trig <= 8'h00;
            r_snd2_trig <= 8'h00;
            if (w_wr2) r_shift_off  <= data[2:0];
            if (w_wr4) r_shift_data <= {data, r_shift_data[15:8]};
            if (w_wr3) begin
                r_snd1      <= data;
                r_snd1_trig <= data & ~r_snd1;
            end
            if (w_wr5) begin
                r_snd2      <= data;
                r_snd2_trig <= data & ~r_snd2;
            end
        end
    end

    assign snd1      = r_snd1;
    assign snd2      = r_snd2;
    assign snd1_trig = r_snd1_trig;
    assign snd2_trig = r_snd2_trig;

    // Watchdog: a kick in the terminal cycle clears the count and eats the pulse.
    assign w_wd_hit    = (r_wd == WD_LAST);
    assign wdog_expire = w_wd_hit && !w_wr6;

    // Watchdog counter, wraps at the terminal count or on a port-6 kick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_wd <= '0;
        else if (w_wr6 || w_wd_hit) r_wd <= '0;
        else                       r_wd <= r_wd + WDW'(1);
    end

endmodule

// File: tb/tb_invaders_io.sv
// Directed bench for invaders_io. Two instances share all inputs: WAIT_STATES=2
// (main checks) and WAIT_STATES=3 (reset during a wait). A released bus is
// probed by driving 0x00 from the bench and confirming nothing else drives it.
module tb_invaders_io;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] port_addr;
    logic       io_rd;
    logic       io_wr;
    logic [7:0] in0, in1, in2;
    logic       tb_oe;
    logic [7:0] tb_dout;
    wire  [7:0] data_a, data_b;
    logic       ready_a, ready_b;
    logic [7:0] snd1_a, snd2_a, snd1_trig_a, snd2_trig_a;
    logic [7:0] snd1_b, snd2_b, snd1_trig_b, snd2_trig_b;
    logic       wdog_a, wdog_b;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign data_a = tb_oe ? tb_dout : 8'hzz;
    assign data_b = tb_oe ? tb_dout : 8'hzz;

    invaders_io #(.WAIT_STATES(2), .WDOG_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .port_addr(port_addr), .data(data_a),
        .io_rd(io_rd), .io_wr(io_wr), .ready(ready_a),
        .in0(in0), .in1(in1), .in2(in2),
        .snd1(snd1_a), .snd2(snd2_a), .snd1_trig(snd1_trig_a), .snd2_trig(snd2_trig_a),
        .wdog_expire(wdog_a)
    );

    invaders_io #(.WAIT_STATES(3), .WDOG_CYCLES(16)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .port_addr(port_addr), .data(data_b),
        .io_rd(io_rd), .io_wr(io_wr), .ready(ready_b),
        .in0(in0), .in1(in1), .in2(in2),
        .snd1(snd1_b), .snd2(snd2_b), .snd1_trig(snd1_trig_b), .snd2_trig(snd2_trig_b),
        .wdog_expire(wdog_b)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; io_rd = 1'b0; io_wr = 1'b0; tb_oe = 1'b0; port_addr = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic out_cyc(input logic [7:0] p, input logic [7:0] v);
        @(negedge clk);
        port_addr = p; tb_dout = v; tb_oe = 1'b1; io_wr = 1'b1;
        @(negedge clk);
        io_wr = 1'b0; tb_oe = 1'b0;
    endtask

    // IN cycle; waits counts sampled cycles with ready low (bounded).
    task automatic in_cyc(input bit sel_b, input logic [7:0] p,
                          output logic [7:0] val, output int waits);
        @(negedge clk);
        port_addr = p; io_rd = 1'b1; waits = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if ((sel_b ? ready_b : ready_a) === 1'b1) break;
            waits++;
            @(negedge clk);
        end
        val   = sel_b ? data_b : data_a;
        io_rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int         w;
        do_reset();
        in1 = 8'h3C;
        tb_oe = 1'b1; tb_dout = 8'h00;
        #1;
        n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready_a); end
        n_vec++; if (data_a !== 8'h00) begin n_err++; $display("FAIL reset_bus got %h want 00", data_a); end
        n_vec++; if ({snd1_a, snd2_a, snd1_trig_a, snd2_trig_a} !== 32'h0)
            begin n_err++; $display("FAIL reset_snd got %h want 00000000", {snd1_a, snd2_a, snd1_trig_a, snd2_trig_a}); end
        n_vec++; if (wdog_a !== 1'b0) begin n_err++; $display("FAIL reset_wdog got %b want 0", wdog_a); end
        tb_oe = 1'b0;
        out_cyc(8'd3, 8'hFF);
        @(negedge clk);
        port_addr = 8'd1; io_rd = 1'b1;
        @(negedge clk);
        n_vec++; if (ready_b !== 1'b0) begin n_err++; $display("FAIL wait_entry got %b want 0", ready_b); end
        @(negedge clk);
        rst_n = 1'b0; tb_oe = 1'b1; tb_dout = 8'h00;
        #1;
        n_vec++; if (ready_b !== 1'b1) begin n_err++; $display("FAIL midwait_rst_ready got %b want 1", ready_b); end
        n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL midwait_rst_ready_a got %b want 1", ready_a); end
        n_vec++; if (data_b !== 8'h00) begin n_err++; $display("FAIL midwait_rst_bus got %h want 00", data_b); end
        n_vec++; if (snd1_b !== 8'h00) begin n_err++; $display("FAIL midwait_rst_snd1 got %h want 00", snd1_b); end
        io_rd = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_cyc(1'b1, 8'd1, v, w);
        n_vec++; if (v !== 8'h3C) begin n_err++; $display("FAIL post_rst_read got %h want 3c", v); end
        n_vec++; if (w !== 3) begin n_err++; $display("FAIL post_rst_waits got %0d want 3", w); end
    endtask

    task automatic test_shift();
        logic [7:0] offs [4] = '{8'h00, 8'h03, 8'hFB, 8'h07};
        logic [7:0] exps [4] = '{8'hCD, 8'h6D, 8'h6D, 8'hD5};
        logic [7:0] v;
        int         w;
        out_cyc(8'd4, 8'hAB);
        out_cyc(8'd4, 8'hCD);
        for (int k = 0; k < 4; k++) begin
            out_cyc(8'd2, offs[k]);
            in_cyc(1'b0, 8'd3, v, w);
            n_vec++; if (v !== exps[k]) begin n_err++; $display("FAIL shift_off%0d got %h want %h", k, v, exps[k]); end
        end
    endtask

    task automatic test_read_wait();
        logic [7:0] v;
        int         w;
        in0 = 8'hC3; in1 = 8'h5A; in2 = 8'h96;
        in_cyc(1'b0, 8'd1, v, w);
        n_vec++; if (w !== 2) begin n_err++; $display("FAIL in1_waits got %0d want 2", w); end
        n_vec++; if (v !== 8'h5A) begin n_err++; $display("FAIL in1_data got %h want 5a", v); end
        tb_oe = 1'b1; tb_dout = 8'h00;
        #1;
        n_vec++; if (data_a !== 8'h00) begin n_err++; $display("FAIL in1_release got %h want 00", data_a); end
        tb_oe = 1'b0;
        in_cyc(1'b0, 8'd0, v, w);
        n_vec++; if (v !== 8'hC3) begin n_err++; $display("FAIL in0_data got %h want c3", v); end
        in_cyc(1'b0, 8'd2, v, w);
        n_vec++; if (v !== 8'h96) begin n_err++; $display("FAIL in2_data got %h want 96", v); end
        @(negedge clk);
        port_addr = 8'd7; io_rd = 1'b1; tb_oe = 1'b1; tb_dout = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL in7_ready c%0d got %b want 1", i, ready_a); end
            n_vec++; if (data_a !== 8'h00) begin n_err++; $display("FAIL in7_bus c%0d got %h want 00", i, data_a); end
        end
        io_rd = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic test_sound();
        out_cyc(8'd3, 8'h05);
        n_vec++; if (snd1_a !== 8'h05) begin n_err++; $display("FAIL snd1_a got %h want 05", snd1_a); end
        n_vec++; if (snd1_trig_a !== 8'h05) begin n_err++; $display("FAIL trig1_a got %h want 05", snd1_trig_a); end
        @(negedge clk);
        n_vec++; if (snd1_trig_a !== 8'h00) begin n_err++; $display("FAIL trig1_a_clr got %h want 00", snd1_trig_a); end
        out_cyc(8'd3, 8'h0F);
        n_vec++; if (snd1_trig_a !== 8'h0A) begin n_err++; $display("FAIL trig1_b got %h want 0a", snd1_trig_a); end
        out_cyc(8'd3, 8'h0F);
        n_vec++; if (snd1_trig_a !== 8'h00) begin n_err++; $display("FAIL trig1_same got %h want 00", snd1_trig_a); end
        out_cyc(8'd5, 8'h81);
        n_vec++; if (snd2_a !== 8'h81) begin n_err++; $display("FAIL snd2 got %h want 81", snd2_a); end
        n_vec++; if (snd2_trig_a !== 8'h81) begin n_err++; $display("FAIL trig2 got %h want 81", snd2_trig_a); end
        n_vec++; if (snd1_trig_a !== 8'h00) begin n_err++; $display("FAIL trig1_quiet got %h want 00", snd1_trig_a); end
        out_cyc(8'd7, 8'hFF);
        n_vec++; if ({snd1_a, snd2_a} !== 16'h0F81) begin n_err++; $display("FAIL port7_noeffect got %h want 0f81", {snd1_a, snd2_a}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        int         w;
        out_cyc(8'd2, 8'h00);
        @(negedge clk);
        port_addr = 8'd3; io_rd = 1'b1;
        @(negedge clk);
        n_vec++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL frz_wait got %b want 0", ready_a); end
        port_addr = 8'd4; io_wr = 1'b1; tb_oe = 1'b1; tb_dout = 8'h12;
        @(negedge clk);
        io_wr = 1'b0; tb_oe = 1'b0; port_addr = 8'd3;
        for (int i = 0; i < 20; i++) begin
            if (ready_a === 1'b1) break;
            @(negedge clk);
        end
        n_vec++; if (data_a !== 8'hCD) begin n_err++; $display("FAIL frz_data got %h want cd", data_a); end
        io_rd = 1'b0;
        in_cyc(1'b0, 8'd3, v, w);
        n_vec++; if (v !== 8'h12) begin n_err++; $display("FAIL frz_after got %h want 12", v); end
    endtask

    task automatic wd_run(input int wr_at, input int p1, input int p2);
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            port_addr = 8'd6; tb_dout = 8'h00;
            io_wr = (c == wr_at); tb_oe = (c == wr_at);
            #1;
            n_vec++;
            if (wdog_a !== ((c == p1) || (c == p2))) begin
                n_err++; $display("FAIL wdog kick%0d c%0d got %b want %b", wr_at, c, wdog_a, (c == p1) || (c == p2));
            end
            @(negedge clk);
        end
        io_wr = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic test_watchdog();
        wd_run(-1, 15, 31);
        wd_run(10, 26, -1);
        wd_run(15, 31, -1);
    endtask

    initial begin
        rst_n = 1'b0; io_rd = 1'b0; io_wr = 1'b0; tb_oe = 1'b0; tb_dout = 8'h00;
        port_addr = 8'h00; in0 = 8'h00; in1 = 8'h00; in2 = 8'h00;
        test_reset();
        test_shift();
        test_read_wait();
        test_sound();
        test_back_to_back();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
